// File: rtl/cg_timer_ctrl.sv
// Prescaled tick timer with one-shot/periodic reload, pause and abort.
// Emits a registered single-cycle expire pulse at terminal count and an error pulse on zero-period start.
module cg_timer_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_pause,
  input  logic                   i_periodic,
  input  logic [DATA_WIDTH-1:0]  i_period,
  input  logic [PRESC_WIDTH-1:0] i_presc,
  output logic                   o_busy,
  output logic                   o_expire,
  output logic                   o_err,
  output logic [DATA_WIDTH-1:0]  o_count
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  count_q, count_d, period_q, period_d;
  logic [PRESC_WIDTH-1:0] psc_q, psc_d, presc_q, presc_d;
  logic                   periodic_q, periodic_d;
  logic                   expire_q, expire_d, err_q, err_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      psc_q      <= '0;
      period_q   <= '0;
      presc_q    <= '0;
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      psc_q      <= psc_d;
      period_q   <= period_d;
      presc_q    <= presc_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    psc_d      = psc_q;
    period_d   = period_q;
    presc_d    = presc_q;
    periodic_d = periodic_q;
    expire_d   = 1'b0;
    err_d      = 1'b0;

    if (i_abort) begin
      state_d = IDLE;
      count_d = '0;
      psc_d   = '0;
    end else if (i_start) begin
      // A zero period is rejected; any running timer is stopped but keeps its registers.
      if (i_period != '0) begin
        period_d   = i_period;
        presc_d    = i_presc;
        periodic_d = i_periodic;
        count_d    = '0;
        psc_d      = '0;
        state_d    = RUN;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (i_pause) begin
            state_d = HOLD;
          end else if (psc_q == presc_q) begin
            psc_d = '0;
            if (count_q == period_q - DATA_WIDTH'(1)) begin
              count_d  = '0;
              expire_d = 1'b1;
              if (!periodic_q) state_d = IDLE;
            end else begin
              count_d = count_q + DATA_WIDTH'(1);
            end
          end else begin
            psc_d = psc_q + PRESC_WIDTH'(1);
          end
        end
        HOLD: begin
          if (!i_pause) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_expire = expire_q;
  assign o_err    = err_q;
  assign o_count  = count_q;

endmodule

// File: tb/tb_cg_timer_ctrl.sv
// Randomized bench for cg_timer_ctrl against an elapsed-cycle reference model.
module tb_cg_timer_ctrl;

  localparam int DW = 32;
  localparam int PW = 8;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_start = 1'b0, i_abort = 1'b0, i_pause = 1'b0, i_periodic = 1'b0;
  logic [DW-1:0] i_period = '0;
  logic [PW-1:0] i_presc = '0;
  logic          o_busy, o_expire, o_err;
  logic [DW-1:0] o_count;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed RUN cycles since last (re)start/expiry.
  bit     m_active, m_held, m_per, m_exp, m_err;
  longint m_e, m_p, m_s;

  cg_timer_ctrl #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_abort(i_abort),
    .i_pause(i_pause), .i_periodic(i_periodic), .i_period(i_period), .i_presc(i_presc),
    .o_busy(o_busy), .o_expire(o_expire), .o_err(o_err), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_held = 0; m_per = 0; m_exp = 0; m_err = 0;
    m_e = 0; m_p = 0; m_s = 0;
  endtask

  // Drive one cycle of inputs and advance the model to the post-edge values.
  task automatic step(input bit st, input bit ab, input bit pa, input bit per,
                      input int period_v, input int presc_v);
    i_start = st; i_abort = ab; i_pause = pa; i_periodic = per;
    i_period = DW'(period_v); i_presc = PW'(presc_v);
    m_exp = 0; m_err = 0;
    if (ab) begin
      m_active = 0; m_held = 0; m_e = 0;
    end else if (st) begin
      if (period_v != 0) begin
        m_active = 1; m_held = 0; m_e = 0;
        m_p = period_v; m_s = presc_v; m_per = per;
      end else begin
        m_err = 1; m_active = 0; m_held = 0;
      end
    end else if (m_active) begin
      if (!m_held) begin
        if (pa) m_held = 1;
        else begin
          m_e++;
          if (m_e == m_p * (m_s + 1)) begin
            m_exp = 1; m_e = 0;
            if (!m_per) m_active = 0;
          end
        end
      end else if (!pa) begin
        m_held = 0;
      end
    end
  endtask

  task automatic check_all();
    check("busy", longint'(o_busy), longint'(m_active));
    check("expire", longint'(o_expire), longint'(m_exp));
    check("err", longint'(o_err), longint'(m_err));
    check("count", longint'(o_count), m_e / (m_s + 1));
  endtask

  initial begin
    bit st, ab, pa, per;
    int pv, sv;
    model_reset();
    #12;
    check_all();
    @(negedge i_clk);
    i_rstn = 1'b1;
    pa = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      check_all();
      if (i == 1500 && i_rstn) begin
        i_rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        i_start = 0; i_abort = 0; i_pause = 0;
        @(negedge i_clk);
        check_all();
        i_rstn = 1'b1;
        pa = 0;
        step(0, 0, 0, 0, 0, 0);
        continue;
      end
      st = 0; ab = 0; per = 0; pv = 0; sv = 0;
      if (i == 0) begin
        st = 1; pv = 4; sv = 0;
      end else if (i == 12) begin
        st = 1; pv = 1; sv = 0; per = 1;
      end else if (i == 20) begin
        st = 1; pv = 3; sv = 1; per = 1;
      end else if (i < 40) begin
        if (i == 38) ab = 1;
      end else begin
        if ($urandom_range(0, 7) == 0) pa = ~pa;
        ab = ($urandom_range(0, 79) == 0);
        st = ($urandom_range(0, 24) == 0);
        per = $urandom_range(0, 1);
        pv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
        sv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 3));
      end
      step(st, ab, pa, per, pv, sv);
    end
    @(negedge i_clk);
    check_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
